// File: rtl/pwm_multiphase_pkg.sv
// ============================================================================
// pwm_multiphase_pkg : shared target-state encodings and counter mode constants
// Revision 1.0 - initial release
// ============================================================================
`ifndef PWM_MULTIPHASE_PKG_SV
`define PWM_MULTIPHASE_PKG_SV
`default_nettype none

package pwm_multiphase_pkg;

  typedef enum logic [1:0] {
    STATE_OFF  = 2'd0,
    STATE_HIGH = 2'd1,
    STATE_LOW  = 2'd2
  } pwm_state_t;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

endpackage

`default_nettype wire
`endif

// File: rtl/pwm_multiphase_deadtime.sv
// ============================================================================
// pwm_deadtime : per-channel dead-time insertion and registered gate drive
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_deadtime
  import pwm_multiphase_pkg::*;
#(
  parameter int deadtime_width = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  pwm_state_t                target,
  input  logic [deadtime_width-1:0] deadtime,
  output logic                      highside_output,
  output logic                      lowside_output,
  output logic                      both_gates_off_output
);

  localparam logic [deadtime_width-1:0] c_dt_one = 1;

  pwm_state_t                last_q, last_d;
  pwm_state_t                drive;
  logic [deadtime_width-1:0] cnt_q, cnt_d;
  logic                      hs_q, hs_d, ls_q, ls_d, off_q, off_d;

  always_comb begin
    last_d = target;
    cnt_d  = '0;
    drive  = STATE_OFF;
    if (target == STATE_OFF) begin
      drive = STATE_OFF;
    end else if (target != last_q && last_q != STATE_OFF) begin
      // Direct HIGH<->LOW swap (also restarts a running countdown).
      if (deadtime == '0) begin
        drive = target;
      end else begin
        drive = STATE_OFF;
        cnt_d = deadtime - c_dt_one;
      end
    end else if (target != last_q) begin
      drive = target;
    end else if (cnt_q != '0) begin
      drive = STATE_OFF;
      cnt_d = cnt_q - c_dt_one;
    end else begin
      drive = target;
    end
    hs_d  = (drive == STATE_HIGH);
    ls_d  = (drive == STATE_LOW);
    off_d = (drive == STATE_OFF);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= STATE_OFF;
      cnt_q  <= '0;
      hs_q   <= 1'b0;
      ls_q   <= 1'b0;
      off_q  <= 1'b1;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      hs_q   <= hs_d;
      ls_q   <= ls_d;
      off_q  <= off_d;
    end
  end

  assign highside_output       = hs_q;
  assign lowside_output        = ls_q;
  assign both_gates_off_output = off_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multiphase.sv
// ============================================================================
// pwm_multiphase : multi-channel PWM counter with shadowed settings
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multiphase
  import pwm_multiphase_pkg::*;
#(
  parameter int bitwidth       = 8,
  parameter int channels       = 3,
  parameter int deadtime_width = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [bitwidth-1:0]          period,
  input  logic                         center_mode,
  input  logic [channels*bitwidth-1:0] tick_count_highside,
  input  logic [channels*bitwidth-1:0] tick_count_lowside,
  input  logic [deadtime_width-1:0]    deadtime,
  input  logic                         load_enable,
  output logic [bitwidth-1:0]          counter_output,
  output logic                         cycle_start,
  output logic [channels-1:0]          highside_output,
  output logic [channels-1:0]          lowside_output,
  output logic [channels-1:0]          both_gates_off_output
);

  localparam logic [bitwidth-1:0] c_cnt_one = 1;

  logic [bitwidth-1:0]          counter_q, counter_d;
  logic                         dir_down_q, dir_down_d;
  logic                         cycle_start_q, cycle_start_d;
  logic [bitwidth-1:0]          period_q, period_d;
  logic                         center_q, center_d;
  logic [deadtime_width-1:0]    deadtime_q, deadtime_d;
  logic [channels*bitwidth-1:0] hs_q, hs_d, ls_q, ls_d;
  logic                         reload;

  // The *_d shadow values are what the counter and channels act on this cycle,
  // so freshly loaded settings already apply at counter 0.
  always_comb begin
    reload     = (counter_q == '0) && load_enable;
    period_d   = reload ? period              : period_q;
    center_d   = reload ? center_mode         : center_q;
    deadtime_d = reload ? deadtime            : deadtime_q;
    hs_d       = reload ? tick_count_highside : hs_q;
    ls_d       = reload ? tick_count_lowside  : ls_q;

    counter_d  = counter_q;
    dir_down_d = dir_down_q;
    if (period_d == '0) begin
      counter_d  = '0;
      dir_down_d = 1'b0;
    end else if (counter_q == '0) begin
      counter_d  = c_cnt_one;
      dir_down_d = 1'b0;
    end else if (dir_down_q) begin
      counter_d = counter_q - c_cnt_one;
    end else if (counter_q < period_d) begin
      counter_d = counter_q + c_cnt_one;
    end else if (center_d == MODE_CENTER) begin
      counter_d  = counter_q - c_cnt_one;
      dir_down_d = 1'b1;
    end else begin
      counter_d = '0;
    end
    cycle_start_d = (counter_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q     <= '0;
      dir_down_q    <= 1'b0;
      cycle_start_q <= 1'b0;
      period_q      <= '0;
      center_q      <= MODE_EDGE;
      deadtime_q    <= '0;
      hs_q          <= '0;
      ls_q          <= '0;
    end else begin
      counter_q     <= counter_d;
      dir_down_q    <= dir_down_d;
      cycle_start_q <= cycle_start_d;
      period_q      <= period_d;
      center_q      <= center_d;
      deadtime_q    <= deadtime_d;
      hs_q          <= hs_d;
      ls_q          <= ls_d;
    end
  end

  assign counter_output = counter_q;
  assign cycle_start    = cycle_start_q;

  for (genvar n = 0; n < channels; n++) begin : g_channel
    logic [bitwidth-1:0] hs_ch, ls_ch;
    logic [bitwidth:0]   low_limit;
    pwm_state_t          target;

    always_comb begin
      hs_ch     = hs_d[n*bitwidth +: bitwidth];
      ls_ch     = ls_d[n*bitwidth +: bitwidth];
      low_limit = {1'b0, hs_ch} + {1'b0, ls_ch};
      if (counter_q < hs_ch) begin
        target = STATE_HIGH;
      end else if ({1'b0, counter_q} < low_limit) begin
        target = STATE_LOW;
      end else begin
        target = STATE_OFF;
      end
    end

    pwm_deadtime #(
      .deadtime_width(deadtime_width)
    ) u_deadtime (
      .clock                (clock),
      .reset                (reset),
      .target               (target),
      .deadtime             (deadtime_d),
      .highside_output      (highside_output[n]),
      .lowside_output       (lowside_output[n]),
      .both_gates_off_output(both_gates_off_output[n])
    );
  end

endmodule

`default_nettype wire
